// File: rtl/rv64i_top.sv
// ---------------------------------------------------------------------------
// rv64i_top -- single-cycle RV64I core with private instruction and data
// memories.
//
// Every rising edge retires one instruction. Fetch, decode, ALU, branch
// resolution and load data are all combinational from current_pc. The
// register file write, the data-memory store and the PC update happen
// together on the clock edge.
//
// Ports:
//   clk : single clock; all state updates on the rising edge
//   rst : asynchronous, active-low reset. While low, current_pc = RESET_PC
//         and x1..x31 = 0. Store enables are gated so an instruction caught
//         by reset never reaches memory.
//
// Parameters:
//   RESET_PC  : PC value loaded on reset
//   EXIT_PC   : program-exit address; software ends by jumping here
//   MEM_BYTES : bytes in each of im.mem / dm.mem (power of two); every
//               address is taken modulo MEM_BYTES
//
// Optional build macro:
//   HALT_AT_EXIT_EN : when defined, the core freezes once current_pc equals
//                     EXIT_PC. The PC holds and no register or memory write
//                     occurs until reset. When undefined, EXIT_PC is an
//                     ordinary address.
//
// Unrecognised encodings (FENCE, ECALL, EBREAK, illegal) retire as NOPs.
// ---------------------------------------------------------------------------

// Byte-addressed little-endian memory. It has a combinational read port of
// DATA_BYTES bytes and a clocked write port of 1/2/4/8 bytes (size_i is
// log2 of the byte count). It shares one address between read and write.
// The contents have no reset.
module Rv64iMem #(
  parameter int MEM_BYTES  = 65536,
  parameter int DATA_BYTES = 8,
  parameter int AW         = $clog2(MEM_BYTES)
) (
  input  logic                    clk,
  input  logic [AW-1:0]           addr_i,
  input  logic                    we_i,
  input  logic [1:0]              size_i,
  input  logic [8*DATA_BYTES-1:0] wdata_i,
  output logic [8*DATA_BYTES-1:0] rdata_o
);

  logic [7:0] mem [0:MEM_BYTES-1];
  logic [3:0] nBytes;

  assign nBytes = 4'd1 << size_i;

  // Each read byte lane has its own index, so a misaligned access simply
  // walks consecutive bytes. The AW-bit addition handles wrap-around.
  for (genvar g = 0; g < DATA_BYTES; g++) begin : gRead
    assign rdata_o[8*g +: 8] = mem[addr_i + AW'(g)];
  end

  // A store writes only the lanes covered by its size. Lanes beyond nBytes
  // keep their old contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (4'(i) < nBytes) begin
          mem[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

endmodule

module rv64i_top #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [63:0] EXIT_PC   = 64'h100,
  parameter int          MEM_BYTES = 65536
) (
  input logic clk,
  input logic rst
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  logic [63:0] current_pc;
  logic [63:0] nextPc_d;
  logic [63:0] pcPlus4;
  logic [63:0] regs_q [0:31];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [63:0] immI;
  logic [63:0] immS;
  logic [63:0] immB;
  logic [63:0] immU;
  logic [63:0] immJ;
  logic [63:0] rs1Val;
  logic [63:0] rs2Val;

  logic        rdWe;
  logic [63:0] rdData;
  logic        dmWe;
  logic        dmWeGated;
  logic [63:0] dmAddr;
  logic [63:0] dmRdata;
  logic        takeBranch;
  logic        halted;

  // 64-bit ALU. alt selects SUB over ADD and SRA over SRL. Shifts use
  // b[5:0] as the shift amount.
  function automatic logic [63:0] alu64(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] f3, input logic alt);
    logic [63:0] r;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[5:0];
      3'b010:  r = {63'd0, $signed(a) < $signed(b)};
      3'b011:  r = {63'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 64'($signed(a) >>> b[5:0]) : (a >> b[5:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // W-variant ALU. It works on the low 32 bits with a 5-bit shift amount
  // and sign-extends the 32-bit result.
  function automatic logic [63:0] aluW(input logic [63:0] a, input logic [63:0] b,
                                       input logic [2:0] f3, input logic alt);
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] r;
    a32 = a[31:0];
    b32 = b[31:0];
    case (f3)
      3'b000:  r = alt ? (a32 - b32) : (a32 + b32);
      3'b001:  r = a32 << b32[4:0];
      3'b101:  r = alt ? 32'($signed(a32) >>> b32[4:0]) : (a32 >> b32[4:0]);
      default: r = 32'd0;
    endcase
    return {{32{r[31]}}, r};
  endfunction

  Rv64iMem #(.MEM_BYTES(MEM_BYTES), .DATA_BYTES(4)) im (
    .clk     (clk),
    .addr_i  (current_pc[AW-1:0]),
    .we_i    (1'b0),
    .size_i  (2'b00),
    .wdata_i (32'h0),
    .rdata_o (instr)
  );

  Rv64iMem #(.MEM_BYTES(MEM_BYTES), .DATA_BYTES(8)) dm (
    .clk     (clk),
    .addr_i  (dmAddr[AW-1:0]),
    .we_i    (dmWeGated),
    .size_i  (funct3[1:0]),
    .wdata_i (rs2Val),
    .rdata_o (dmRdata)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign immI = {{52{instr[31]}}, instr[31:20]};
  assign immS = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign immB = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immU = {{32{instr[31]}}, instr[31:12], 12'd0};
  assign immJ = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1Val  = (rs1 == 5'd0) ? 64'd0 : regs_q[rs1];
  assign rs2Val  = (rs2 == 5'd0) ? 64'd0 : regs_q[rs2];
  assign pcPlus4 = current_pc + 64'd4;

`ifdef HALT_AT_EXIT_EN
  assign halted = (current_pc == EXIT_PC);
`else
  assign halted = 1'b0;
`endif

  // The store is suppressed while reset is held, which aborts an
  // instruction caught by reset. It is also suppressed once the core has
  // halted.
  assign dmWeGated = dmWe & rst & ~halted;

  // Decode and execute. The defaults describe a NOP: PC advances by 4 and
  // nothing is written. Each legal encoding then enables its own write-back
  // and/or redirects the PC. Encodings that fall through any validity check
  // keep the NOP defaults.
  always_comb begin
    nextPc_d   = pcPlus4;
    rdWe       = 1'b0;
    rdData     = 64'd0;
    dmWe       = 1'b0;
    dmAddr     = rs1Val + immI;
    takeBranch = 1'b0;
    case (opcode)
      OP_LUI: begin
        rdWe   = 1'b1;
        rdData = immU;
      end
      OP_AUIPC: begin
        rdWe   = 1'b1;
        rdData = current_pc + immU;
      end
      OP_JAL: begin
        rdWe     = 1'b1;
        rdData   = pcPlus4;
        nextPc_d = current_pc + immJ;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rdWe     = 1'b1;
          rdData   = pcPlus4;
          nextPc_d = (rs1Val + immI) & ~64'd1;
        end
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  takeBranch = (rs1Val == rs2Val);
          3'b001:  takeBranch = (rs1Val != rs2Val);
          3'b100:  takeBranch = ($signed(rs1Val) <  $signed(rs2Val));
          3'b101:  takeBranch = ($signed(rs1Val) >= $signed(rs2Val));
          3'b110:  takeBranch = (rs1Val <  rs2Val);
          3'b111:  takeBranch = (rs1Val >= rs2Val);
          default: takeBranch = 1'b0;
        endcase
        if (takeBranch) begin
          nextPc_d = current_pc + immB;
        end
      end
      OP_LOAD: begin
        rdWe = 1'b1;
        case (funct3)
          3'b000:  rdData = {{56{dmRdata[7]}},  dmRdata[7:0]};
          3'b001:  rdData = {{48{dmRdata[15]}}, dmRdata[15:0]};
          3'b010:  rdData = {{32{dmRdata[31]}}, dmRdata[31:0]};
          3'b011:  rdData = dmRdata;
          3'b100:  rdData = {56'd0, dmRdata[7:0]};
          3'b101:  rdData = {48'd0, dmRdata[15:0]};
          3'b110:  rdData = {32'd0, dmRdata[31:0]};
          default: rdWe   = 1'b0;
        endcase
      end
      OP_STORE: begin
        dmAddr = rs1Val + immS;
        dmWe   = ~funct3[2];
      end
      OP_IMM: begin
        // Immediate shifts carry a 6-bit shamt. The top six immediate bits
        // must be all-zero, or 010000 for SRAI.
        if (funct3 == 3'b001) begin
          rdWe = (instr[31:26] == 6'b000000);
        end else if (funct3 == 3'b101) begin
          rdWe = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
        end else begin
          rdWe = 1'b1;
        end
        rdData = alu64(rs1Val, immI, funct3, (funct3 == 3'b101) & instr[30]);
      end
      OP_REG: begin
        rdWe   = (funct7 == 7'b0000000) ||
                 ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        rdData = alu64(rs1Val, rs2Val, funct3, instr[30]);
      end
      OP_IMM32: begin
        case (funct3)
          3'b000:  rdWe = 1'b1;
          3'b001:  rdWe = (funct7 == 7'b0000000);
          3'b101:  rdWe = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: rdWe = 1'b0;
        endcase
        rdData = aluW(rs1Val, immI, funct3, (funct3 == 3'b101) & instr[30]);
      end
      OP_REG32: begin
        case (funct3)
          3'b000, 3'b101: rdWe = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          3'b001:         rdWe = (funct7 == 7'b0000000);
          default:        rdWe = 1'b0;
        endcase
        rdData = aluW(rs1Val, rs2Val, funct3, instr[30]);
      end
      default: begin
      end
    endcase
  end

  // PC and register file share one state block. Reset clears both
  // asynchronously. After a halt both hold. x0 is never written, so it
  // stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      current_pc <= RESET_PC;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 64'd0;
      end
    end else if (!halted) begin
      current_pc <= nextPc_d;
      if (rdWe && (rd != 5'd0)) begin
        regs_q[rd] <= rdData;
      end
    end
  end

endmodule

// File: tb/tb_rv64i_top.sv
// ---------------------------------------------------------------------------
// tb_rv64i_top -- directed self-checking bench for rv64i_top.
//
// Each program is hand-assembled into both im.mem and dm.mem while the core
// is held in reset. Address 0x100 always holds "jal x0,0", so the exit
// address is a resting point in either build. After release the bench runs
// until current_pc reaches 0x100, then compares data-memory words against
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_rv64i_top;

  localparam logic [63:0] EXIT_ADDR = 64'h100;
  localparam logic [6:0]  OPIMM     = 7'b0010011;
  localparam logic [6:0]  OPIMM32   = 7'b0011011;
  localparam logic [6:0]  OPR       = 7'b0110011;
  localparam logic [6:0]  OPR32     = 7'b0111011;
  localparam logic [6:0]  OPLOAD    = 7'b0000011;
  localparam logic [6:0]  OPLUI     = 7'b0110111;
  localparam logic [6:0]  OPAUIPC   = 7'b0010111;
  localparam logic [6:0]  OPJALR    = 7'b1100111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;
  int   progAddr   = 0;

  rv64i_top dut (
    .clk (clk),
    .rst (rst)
  );

  // Free-running 10-time-unit clock.
  initial forever #5 clk = ~clk;

  // Single comparison point: count the check and report any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] rType(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd, input logic [6:0] op);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] iType(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] sType(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] bType(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] uType(input int imm20, input int rd, input logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] jType(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  function automatic logic [63:0] readDm64(input int addr);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) begin
      v[8*b +: 8] = dut.dm.mem[addr + b];
    end
    return v;
  endfunction

  // Put one instruction word into both memories at progAddr.
  task automatic emit(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      dut.im.mem[progAddr + b] = w[8*b +: 8];
      dut.dm.mem[progAddr + b] = w[8*b +: 8];
    end
    progAddr += 4;
  endtask

  task automatic fillDm(input int addr, input int n, input logic [7:0] val);
    for (int i = 0; i < n; i++) begin
      dut.dm.mem[addr + i] = val;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Assert reset and wipe both memories ready for a new image.
  task automatic beginProgram();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      dut.im.mem[i] = 8'h00;
      dut.dm.mem[i] = 8'h00;
    end
    progAddr = 0;
  endtask

  // Close the program with a jump to the exit and park a self-loop there.
  task automatic finishProgram();
    emit(jType(int'(EXIT_ADDR) - progAddr, 0));
    progAddr = int'(EXIT_ADDR);
    emit(jType(0, 0));
  endtask

  // Release reset on a falling edge so the first rising edge executes pc 0.
  task automatic applyStimulus();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic runToExit(input string tag);
    int cyc = 0;
    while ((dut.current_pc !== EXIT_ADDR) && (cyc < 500)) begin
      stepCycle();
      cyc++;
    end
    checkOutput(tag, dut.current_pc, EXIT_ADDR);
  endtask

  initial begin
    // ---- basic arithmetic, plus reset hold and abort ----
    beginProgram();
    fillDm('h200, 1, 8'hAA);
    emit(sType('h200, 0, 0, 0));                 // sb   x0,0x200(x0)
    emit(uType(9, 10, OPLUI));                   // lui  x10,9
    emit(iType(5, 0, 0, 1, OPIMM));              // addi x1,x0,5
    emit(iType(-3, 0, 0, 2, OPIMM));             // addi x2,x0,-3
    emit(rType(0, 2, 1, 0, 3, OPR));             // add  x3,x1,x2
    emit(sType(0, 3, 10, 3));                    // sd   x3,0(x10)
    finishProgram();
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("rstPcHold", dut.current_pc, 64'h0);
      checkOutput("rstNoStore", {56'd0, dut.dm.mem['h200]}, 64'hAA);
    end
    applyStimulus();
    stepCycle();
    checkOutput("pcAfterRelease", dut.current_pc, 64'h4);
    checkOutput("firstStore", {56'd0, dut.dm.mem['h200]}, 64'h0);
    runToExit("exitBasic");
    checkOutput("addResult", readDm64('h9000), 64'h2);

    // ---- loads, sign/zero extension, store widths ----
    beginProgram();
    fillDm('h9000, 64, 8'h11);
    emit(uType(9, 10, OPLUI));                   // lui  x10,9
    emit(iType('h80, 0, 0, 1, OPIMM));           // addi x1,x0,0x80
    emit(sType(0, 1, 10, 2));                    // sw   x1,0(x10)
    emit(iType(0, 10, 0, 2, OPLOAD));            // lb   x2,0(x10)
    emit(iType(0, 10, 4, 3, OPLOAD));            // lbu  x3,0(x10)
    emit(sType(8, 2, 10, 3));                    // sd   x2,8(x10)
    emit(sType(16, 3, 10, 3));                   // sd   x3,16(x10)
    emit(iType(9, 10, 2, 4, OPLOAD));            // lw   x4,9(x10)
    emit(iType(9, 10, 6, 5, OPLOAD));            // lwu  x5,9(x10)
    emit(iType(8, 10, 5, 6, OPLOAD));            // lhu  x6,8(x10)
    emit(iType(16, 10, 3, 7, OPLOAD));           // ld   x7,16(x10)
    emit(sType(24, 4, 10, 3));                   // sd   x4,24(x10)
    emit(sType(32, 5, 10, 3));                   // sd   x5,32(x10)
    emit(sType(40, 6, 10, 3));                   // sd   x6,40(x10)
    emit(sType('h31, 2, 10, 1));                 // sh   x2,0x31(x10)
    emit(sType(56, 7, 10, 3));                   // sd   x7,56(x10)
    finishProgram();
    applyStimulus();
    runToExit("exitLoads");
    checkOutput("swWidth",    readDm64('h9000), 64'h1111111100000080);
    checkOutput("lbSext",     readDm64('h9008), 64'hFFFFFFFFFFFFFF80);
    checkOutput("lbuZext",    readDm64('h9010), 64'h0000000000000080);
    checkOutput("lwMisalign", readDm64('h9018), 64'hFFFFFFFFFFFFFFFF);
    checkOutput("lwuZext",    readDm64('h9020), 64'h00000000FFFFFFFF);
    checkOutput("lhuZext",    readDm64('h9028), 64'h000000000000FF80);
    checkOutput("shTwoBytes", readDm64('h9030), 64'h1111111111FF8011);
    checkOutput("ldValue",    readDm64('h9038), 64'h0000000000000080);

    // ---- W-ops, 64-bit shifts, compares, auipc ----
    beginProgram();
    emit(uType(9, 10, OPLUI));                   // lui    x10,9
    emit(uType(1, 18, OPAUIPC));                 // auipc  x18,1      (pc 0x4)
    emit(iType('h7ff, 0, 0, 5, OPIMM32));        // addiw  x5,x0,0x7ff
    emit(iType(21, 5, 1, 5, OPIMM32));           // slliw  x5,x5,21
    emit(uType('h80000, 6, OPLUI));              // lui    x6,0x80000
    emit(iType(4, 0, 0, 7, OPIMM));              // addi   x7,x0,4
    emit(rType('h20, 7, 6, 5, 8, OPR32));        // sraw   x8,x6,x7
    emit(rType(0, 7, 6, 5, 9, OPR32));           // srlw   x9,x6,x7
    emit(rType('h20, 7, 0, 0, 11, OPR32));       // subw   x11,x0,x7
    emit(rType('h20, 7, 6, 5, 12, OPR));         // sra    x12,x6,x7
    emit(rType(0, 7, 6, 5, 13, OPR));            // srl    x13,x6,x7
    emit(rType(0, 6, 7, 3, 14, OPR));            // sltu   x14,x7,x6
    emit(rType(0, 7, 6, 2, 15, OPR));            // slt    x15,x6,x7
    emit(iType(1, 0, 0, 1, OPIMM));              // addi   x1,x0,1
    emit(iType('h03F, 1, 1, 16, OPIMM));         // slli   x16,x1,63
    emit(iType('h43F, 16, 5, 17, OPIMM));        // srai   x17,x16,63
    emit(iType(65, 0, 0, 24, OPIMM));            // addi   x24,x0,65
    emit(rType(0, 24, 1, 1, 25, OPR));           // sll    x25,x1,x24
    emit(rType(0, 24, 1, 1, 26, OPR32));         // sllw   x26,x1,x24
    emit(sType(0, 5, 10, 3));
    emit(sType(8, 8, 10, 3));
    emit(sType(16, 9, 10, 3));
    emit(sType(24, 11, 10, 3));
    emit(sType(32, 12, 10, 3));
    emit(sType(40, 13, 10, 3));
    emit(sType(48, 14, 10, 3));
    emit(sType(56, 15, 10, 3));
    emit(sType(64, 16, 10, 3));
    emit(sType(72, 17, 10, 3));
    emit(sType(80, 18, 10, 3));
    emit(sType(88, 25, 10, 3));
    emit(sType(96, 26, 10, 3));
    finishProgram();
    applyStimulus();
    runToExit("exitAlu");
    checkOutput("slliw",  readDm64('h9000), 64'hFFFFFFFFFFE00000);
    checkOutput("sraw",   readDm64('h9008), 64'hFFFFFFFFF8000000);
    checkOutput("srlw",   readDm64('h9010), 64'h0000000008000000);
    checkOutput("subw",   readDm64('h9018), 64'hFFFFFFFFFFFFFFFC);
    checkOutput("sra",    readDm64('h9020), 64'hFFFFFFFFF8000000);
    checkOutput("srl",    readDm64('h9028), 64'h0FFFFFFFF8000000);
    checkOutput("sltu",   readDm64('h9030), 64'h1);
    checkOutput("slt",    readDm64('h9038), 64'h1);
    checkOutput("slli63", readDm64('h9040), 64'h8000000000000000);
    checkOutput("srai63", readDm64('h9048), 64'hFFFFFFFFFFFFFFFF);
    checkOutput("auipc",  readDm64('h9050), 64'h0000000000001004);
    checkOutput("sll6b",  readDm64('h9058), 64'h2);
    checkOutput("sllw5b", readDm64('h9060), 64'h2);

    // ---- control flow and x0 writes ----
    beginProgram();
    fillDm('h9000, 48, 8'hFF);
    emit(uType(9, 10, OPLUI));                   // 0x00 lui  x10,9
    emit(iType(1, 0, 0, 1, OPIMM));              // 0x04 addi x1,x0,1
    emit(iType(-1, 0, 0, 2, OPIMM));             // 0x08 addi x2,x0,-1
    emit(bType(8, 1, 1, 0));                     // 0x0c beq  x1,x1,+8  taken
    emit(iType(1, 20, 0, 20, OPIMM));            // 0x10 addi x20,x20,1
    emit(bType(8, 2, 1, 0));                     // 0x14 beq  x1,x2,+8  not taken
    emit(iType(1, 0, 0, 21, OPIMM));             // 0x18 addi x21,x0,1
    emit(bType(8, 1, 2, 6));                     // 0x1c bltu x2,x1,+8  not taken
    emit(iType(1, 0, 0, 22, OPIMM));             // 0x20 addi x22,x0,1
    emit(bType(8, 1, 2, 4));                     // 0x24 blt  x2,x1,+8  taken
    emit(iType(2, 20, 0, 20, OPIMM));            // 0x28 addi x20,x20,2
    emit(bType(8, 2, 1, 1));                     // 0x2c bne  x1,x2,+8  taken
    emit(iType(4, 20, 0, 20, OPIMM));            // 0x30 addi x20,x20,4
    emit(bType(8, 2, 1, 5));                     // 0x34 bge  x1,x2,+8  taken
    emit(iType(8, 20, 0, 20, OPIMM));            // 0x38 addi x20,x20,8
    emit(bType(8, 2, 1, 7));                     // 0x3c bgeu x1,x2,+8  not taken
    emit(iType(1, 0, 0, 23, OPIMM));             // 0x40 addi x23,x0,1
    emit(iType('h51, 0, 0, 3, OPIMM));           // 0x44 addi x3,x0,0x51
    emit(iType(0, 3, 0, 4, OPJALR));             // 0x48 jalr x4,0(x3) -> 0x50
    emit(iType(16, 20, 0, 20, OPIMM));           // 0x4c addi x20,x20,16
    emit(iType(7, 0, 0, 0, OPIMM));              // 0x50 addi x0,x0,7
    emit(sType(0, 20, 10, 3));
    emit(sType(8, 21, 10, 3));
    emit(sType(16, 22, 10, 3));
    emit(sType(24, 23, 10, 3));
    emit(sType(32, 4, 10, 3));
    emit(sType(40, 0, 10, 3));
    finishProgram();
    applyStimulus();
    runToExit("exitBranch");
    checkOutput("branchFlags", readDm64('h9000), 64'h0);
    checkOutput("beqNotTaken", readDm64('h9008), 64'h1);
    checkOutput("bltuNotTakn", readDm64('h9010), 64'h1);
    checkOutput("bgeuNotTakn", readDm64('h9018), 64'h1);
    checkOutput("jalrLink",    readDm64('h9020), 64'h4C);
    checkOutput("x0Write",     readDm64('h9028), 64'h0);
    for (int c = 0; c < 10; c++) begin
      stepCycle();
      checkOutput("exitHold", dut.current_pc, EXIT_ADDR);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
